uart_rx_engine: RTL
===================

Name: uart_rx_engine

Overview:
UART receive path that consumes the serial line and the receive oversampling enable from the baud generator. It deserializes 8N1 frames into bytes and buffers them in a small first-word-fall-through FIFO. The register interface reads bytes from this FIFO and sees sticky frame-error and overrun flags.

Parameters:
DATA_BITS, 8, data bits per frame, sent LSB first
OVERSAMPLE, 16, i_ce ticks per bit period; must be even and at least 4
FIFO_DEPTH, 4, receive FIFO entries; must be a power of 2

Ports:
i_clock  in  1  system clock; the only clock
i_reset  in  1  synchronous, active-high reset
i_ce  in  1  oversample tick from the baud generator, one-cycle pulse
i_rx  in  1  asynchronous serial input; idles high
i_rdEnable  in  1  pop head of FIFO; ignored when o_valid=0
i_clrErr  in  1  clears o_frameError and o_overrun
o_data  out  DATA_BITS  FIFO head; valid while o_valid=1
o_valid  out  1  FIFO not empty
o_busy  out  1  state machine not in IDLE
o_frameError  out  1  sticky: stop bit sampled low
o_overrun  out  1  sticky: byte dropped because FIFO was full

Behaviour:
- Clock and reset: one clock, i_clock. i_reset is synchronous and active-high.
- Reset values: state=IDLE; synchronizer stages=1; FIFO empty; o_valid=0, o_busy=0, o_frameError=0, o_overrun=0, o_data=0.
- A mid-frame reset aborts the frame and discards it.
- Input sync: i_rx passes through 2 flip-flops, giving rxs. All sampling uses rxs.
- All state-machine counting advances only on cycles with i_ce=1. The FIFO and flag logic run every clock.
- IDLE: on a tick with rxs=0, go to START and clear the tick counter.
- START: count OVERSAMPLE/2 ticks, then sample at the centre of the start bit.
  - rxs=1: treat as a glitch and return to IDLE. No flag is set.
  - rxs=0: go to DATA, clear the tick counter and clear the bit counter.
- DATA: every OVERSAMPLE ticks, sample rxs into the shift register, LSB first.
  - After DATA_BITS samples, go to STOP.
- STOP: after OVERSAMPLE ticks, sample rxs.
  - rxs=1: push the byte to the FIFO and go to IDLE.
  - rxs=0: discard the byte, set o_frameError and go to BREAK.
- BREAK: stay until a tick with rxs=1, then go to IDLE. This prevents a break condition from retriggering reception.
- Latency: the push becomes visible as o_valid=1 on the clock after the stop-bit sample tick.
- FIFO: first-word-fall-through. o_data=mem[rdPtr] combinationally.
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = (MSBs differ) and (low bits equal). empty = (pointers equal).
- Pop: i_rdEnable with o_valid=1 advances rdPtr. i_rdEnable with o_valid=0 has no effect.
- Push while full: if a pop occurs in the same cycle, the push is accepted and no overrun is flagged. Otherwise the byte is dropped, o_overrun is set and the FIFO is unchanged.
- Simultaneous push and pop while empty: the push is accepted and o_valid=1 on the next cycle. The pop is ignored.
- Flags: i_clrErr clears both flags. If a set event and i_clrErr occur in the same cycle, the set wins.
- o_busy=1 in START, DATA, STOP and BREAK.

Test Plan:
- Single byte: i_ce=1 every clock, OVERSAMPLE=16. Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clocks/bit. Required: o_valid rises; o_data=0xA5; one i_rdEnable pulse sets o_valid=0; both flags stay 0.
- Glitch rejection: drive i_rx low for 5 clocks, then high. Required: o_busy pulses, returns to IDLE, no push, o_frameError=0.
- Frame error: send 0x3C with the stop bit held low, then hold i_rx low for 40 clocks, then high. Required: o_frameError=1, FIFO empty, state stays BREAK until i_rx goes high. A following good 0x11 is received correctly. Pulse i_clrErr: o_frameError=0.
- Overrun: with no reads, send 0x01..0x05 with FIFO_DEPTH=4. Required: o_overrun=1 after the 5th byte; reads return 0x01,0x02,0x03,0x04, then o_valid=0.
- Full plus simultaneous pop: fill the FIFO with 4 bytes, then assert i_rdEnable on the exact push cycle of byte 0x55. Required: o_overrun=0; reads return 0x02,0x03,0x04,0x55.
- Reset mid-frame and sparse i_ce: with i_ce every 3rd clock, assert i_reset during DATA of 0x7E. Required: all outputs return to reset values; the next 0x7E sent at 48 clocks/bit is received correctly.

Source files
------------

// File: rtl/uart_rx_engine.sv
// UART 8N1 receive engine: input synchronizer, oversampled frame FSM,
// first-word-fall-through receive FIFO and sticky error flags.
module uart_rx_engine #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_ce,
  input  logic                 i_rx,
  input  logic                 i_rdEnable,
  input  logic                 i_clrErr,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_frameError,
  output logic                 o_overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] TICK_ONE  = CW'(1);
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_ONE   = BW'(1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state_r, state_next_s;
  logic [CW-1:0]          tick_r, tick_next_s;
  logic [BW-1:0]          bit_r, bit_next_s;
  logic [DATA_BITS-1:0]   shift_r, shift_next_s;
  logic                   rx_meta_r, rxs_r;
  logic                   push_s, ferr_set_s;

  logic [DATA_BITS-1:0]   mem_r [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_r, rd_ptr_r;
  logic                   full_s, empty_s, pop_s, push_ok_s, ovr_set_s;
  logic                   frame_error_r, overrun_r;

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rx_meta_r <= 1'b1;
      rxs_r     <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rxs_r     <= rx_meta_r;
    end
  end

  // Frame FSM state and counters.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r <= IDLE;
      tick_r  <= '0;
      bit_r   <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_next_s;
      tick_r  <= tick_next_s;
      bit_r   <= bit_next_s;
      shift_r <= shift_next_s;
    end
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_next_s = state_r;
    tick_next_s  = tick_r;
    bit_next_s   = bit_r;
    shift_next_s = shift_r;
    push_s       = 1'b0;
    ferr_set_s   = 1'b0;
    if (i_ce) begin
      case (state_r)
        IDLE: begin
          if (!rxs_r) begin
            state_next_s = START;
            tick_next_s  = '0;
          end else begin
            state_next_s = IDLE;
          end
        end
        START: begin
          if (tick_r == HALF_LAST) begin
            if (rxs_r) begin
              state_next_s = IDLE;
            end else begin
              state_next_s = DATA;
              tick_next_s  = '0;
              bit_next_s   = '0;
            end
          end else begin
            tick_next_s = tick_r + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_r == FULL_LAST) begin
            tick_next_s  = '0;
            shift_next_s = {rxs_r, shift_r[DATA_BITS-1:1]};
            if (bit_r == BIT_LAST) begin
              state_next_s = STOP;
            end else begin
              bit_next_s = bit_r + BIT_ONE;
            end
          end else begin
            tick_next_s = tick_r + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_r == FULL_LAST) begin
            tick_next_s = '0;
            if (rxs_r) begin
              push_s       = 1'b1;
              state_next_s = IDLE;
            end else begin
              ferr_set_s   = 1'b1;
              state_next_s = BREAK;
            end
          end else begin
            tick_next_s = tick_r + TICK_ONE;
          end
        end
        BREAK: begin
          if (rxs_r) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = BREAK;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO is then accepted.
  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s     = i_rdEnable && !empty_s;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign ovr_set_s = push_s && full_s && !pop_s;

  // Receive FIFO storage and pointers.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
        wr_ptr_r                <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      frame_error_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      if (ferr_set_s) begin
        frame_error_r <= 1'b1;
      end else if (i_clrErr) begin
        frame_error_r <= 1'b0;
      end
      if (ovr_set_s) begin
        overrun_r <= 1'b1;
      end else if (i_clrErr) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign o_data       = mem_r[rd_ptr_r[AW-1:0]];
  assign o_valid      = !empty_s;
  assign o_busy       = (state_r != IDLE);
  assign o_frameError = frame_error_r;
  assign o_overrun    = overrun_r;

endmodule
